// File: rtl/ram_responder.sv
// ram_responder: word-organised RAM model behind the memory controller.
// A request is held on ramREN/ramWEN + ramaddr. It is answered with one ACCESS cycle LAT
// cycles after it first appears. Any change of address or op while it waits restarts the count.
// Optional feature: define RAM_ALIGN_CHECK_EN to reject non-word-aligned addresses with ERROR.
module ram_responder #(
    parameter int DEPTH = 16384,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    // ramstate_t encoding
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = $clog2(LAT) + 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
    // LAT==1 never uses the counter; keep the reload value harmless there
    localparam logic [CW-1:0] CNT_RELOAD = (LAT >= 2) ? CW'(LAT - 2) : '0;

    generate
        if (LAT < 1) begin : g_lat_chk
            $error("ram_responder: LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

    state_t        state, nstate;
    logic [31:0]   addr_q, naddr;
    logic [1:0]    op_q, nop;
    logic [CW-1:0] cnt, ncnt;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic          req, bad, misal, same, we;
    logic [1:0]    op;
    logic [AW-1:0] idx;

    assign req = ramREN | ramWEN;
    assign op  = {ramREN, ramWEN};
    assign idx = ramaddr[AW+1:2];

`ifdef RAM_ALIGN_CHECK_EN
    assign misal = (ramaddr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign bad  = req & ((ramREN & ramWEN) | ({1'b0, ramaddr} >= LIMIT) | misal);
    assign same = (ramaddr == addr_q) && (op == op_q);

    // State and latched request registers; reset abandons any in-flight transaction
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            addr_q <= '0;
            op_q   <= '0;
            cnt    <= '0;
        end else begin
            state  <= nstate;
            addr_q <= naddr;
            op_q   <= nop;
            cnt    <= ncnt;
        end
    end

    // Next-state: new or changed requests (re)start the latency count
    always_comb begin
        nstate = state;
        naddr  = addr_q;
        nop    = op_q;
        ncnt   = cnt;
        if (bad) begin
            nstate = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        naddr  = ramaddr;
                        nop    = op;
                        ncnt   = CNT_RELOAD;
                        nstate = (LAT == 1) ? S_ACC : S_WAIT;
                    end
                end
                S_WAIT, S_ACC: begin
                    if (!req) begin
                        nstate = S_IDLE;
                    end else if (!same) begin
                        naddr  = ramaddr;
                        nop    = op;
                        ncnt   = CNT_RELOAD;
                        nstate = (LAT == 1) ? S_ACC : S_WAIT;
                    end else if (state == S_ACC) begin
                        nstate = S_IDLE;
                    end else if (cnt == '0) begin
                        nstate = S_ACC;
                    end else begin
                        ncnt = cnt - 1'b1;
                    end
                end
                default: nstate = S_IDLE;
            endcase
        end
    end

    // Outputs: ramstate/ramload decoded from state and live inputs; write enable for the ACC edge
    always_comb begin
        ramstate = FREE;
        ramload  = '0;
        we       = 1'b0;
        if (RST) begin
            ramstate = FREE;
        end else if (bad) begin
            ramstate = ERROR;
        end else begin
            case (state)
                S_IDLE: ramstate = req ? BUSY : FREE;
                S_WAIT: ramstate = BUSY;
                S_ACC: begin
                    if (req && same) begin
                        ramstate = ACCESS;
                        if (ramREN) ramload = mem[idx];
                        else        we      = 1'b1;
                    end else begin
                        ramstate = BUSY;
                    end
                end
                default: ramstate = FREE;
            endcase
        end
    end

    // Storage write, committed on the edge that ends the ACCESS cycle
    always_ff @(posedge CLK) begin
        if (we) mem[idx] <= ramstore;
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder.
// Two instances share stimulus through a selector: dut0 with LAT=2 and dut1 with LAT=1.
module tb_ram_responder;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam int DEPTH = 16384;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        sel = 1'b0;
    logic        ramREN = 1'b0, ramWEN = 1'b0;
    logic [31:0] ramaddr = '0, ramstore = '0;

    logic        ren0, wen0, ren1, wen1;
    logic [31:0] ld0, ld1, ld;
    logic [1:0]  st0, st1, st;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] sbq [$];

    assign ren0 = ramREN & ~sel;
    assign wen0 = ramWEN & ~sel;
    assign ren1 = ramREN & sel;
    assign wen1 = ramWEN & sel;
    assign st   = sel ? st1 : st0;
    assign ld   = sel ? ld1 : ld0;

    ram_responder #(.DEPTH(DEPTH), .LAT(2)) dut0 (
        .CLK(CLK), .RST(RST), .ramREN(ren0), .ramWEN(wen0), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ld0), .ramstate(st0));

    ram_responder #(.DEPTH(DEPTH), .LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .ramREN(ren1), .ramWEN(wen1), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ld1), .ramstate(st1));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request, expect BUSY until ACCESS after lat cycles, then drop it.
    task automatic do_access(input string tag, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp, input int lat);
        int cyc;
        bit seen;
        logic [31:0] e;
        ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        sbq.push_back(exp);
        seen = 1'b0;
        for (cyc = 0; cyc <= 16; cyc++) begin
            @(negedge CLK);
            if (st == ACCESS) begin
                seen = 1'b1;
                break;
            end
            chk({tag, "_busy"}, 32'(st), 32'(BUSY));
            @(posedge CLK); #1;
        end
        e = sbq.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'(cyc), 32'(lat));
            chk({tag, "_load"}, ld, e);
        end
        @(posedge CLK); #1;
        ramREN = 1'b0; ramWEN = 1'b0;
    endtask

    initial begin
        // reset with a request pending: FREE, never ERROR
        ramREN = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_state", 32'(st), 32'(FREE));
            chk("rst_load", ld, 32'd0);
        end
        @(posedge CLK); #1;
        ramREN = 1'b0; RST = 1'b0;
        @(negedge CLK);
        chk("idle_state", 32'(st), 32'(FREE));
        chk("idle_load", ld, 32'd0);
        @(posedge CLK); #1;

        // write then read back, LAT=2
        do_access("wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 2);
        do_access("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2);

        // restart: address switched after one cycle
        do_access("wr10", 1'b0, 1'b1, 32'h10, 32'h11111111, 32'h0, 2);
        do_access("wr14", 1'b0, 1'b1, 32'h14, 32'h55555555, 32'h0, 2);
        ramREN = 1'b1; ramaddr = 32'h10;
        @(negedge CLK);
        chk("rs_t0", 32'(st), 32'(BUSY));
        @(posedge CLK); #1;
        ramaddr = 32'h14;
        @(negedge CLK);
        chk("rs_t1", 32'(st), 32'(BUSY));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rs_t2", 32'(st), 32'(BUSY));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rs_t3", 32'(st), 32'(ACCESS));
        chk("rs_load", ld, 32'h55555555);
        @(posedge CLK); #1;
        ramREN = 1'b0;
        do_access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 2);

        // error cases
        ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h40;
        @(negedge CLK);
        chk("err_both", 32'(st), 32'(ERROR));
        chk("err_both_load", ld, 32'd0);
        @(posedge CLK); #1;
        ramREN = 1'b0; ramaddr = 32'(DEPTH * 4); ramstore = 32'hBAD0BAD0;
        repeat (3) begin
            @(negedge CLK);
            chk("err_range", 32'(st), 32'(ERROR));
            @(posedge CLK); #1;
        end
        ramWEN = 1'b0;
        do_access("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2);
`ifdef RAM_ALIGN_CHECK_EN
        ramREN = 1'b1; ramaddr = 32'h42;
        @(negedge CLK);
        chk("err_align", 32'(st), 32'(ERROR));
        @(posedge CLK); #1;
        ramREN = 1'b0;
`else
        do_access("rd42", 1'b1, 1'b0, 32'h42, 32'h0, 32'hDEADBEEF, 2);
`endif

        // abort a write with reset
        ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'h1234;
        @(negedge CLK);
        chk("ab_t0", 32'(st), 32'(BUSY));
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("ab_rst", 32'(st), 32'(FREE));
        @(posedge CLK); #1;
        RST = 1'b0; ramWEN = 1'b0;
        @(negedge CLK);
        chk("ab_free", 32'(st), 32'(FREE));
        @(posedge CLK); #1;
        do_access("rd80", 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 2);

        // back-to-back reads on the LAT=1 instance
        sel = 1'b1;
        do_access("w1_0", 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 32'h0, 1);
        do_access("w1_4", 1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, 32'h0, 1);
        do_access("w1_8", 1'b0, 1'b1, 32'h8, 32'hC2C2C2C2, 32'h0, 1);
        begin
            int n;
            int last;
            logic [31:0] e;
            n = 0; last = 0;
            sbq.push_back(32'hA0A0A0A0);
            sbq.push_back(32'hB1B1B1B1);
            sbq.push_back(32'hC2C2C2C2);
            ramREN = 1'b1; ramaddr = 32'h0;
            for (int c = 0; c < 20 && n < 3; c++) begin
                @(negedge CLK);
                if (st == ACCESS) begin
                    e = sbq.pop_front();
                    chk("b2b_load", ld, e);
                    if (n > 0) chk("b2b_gap", 32'(c - last), 32'd2);
                    last = c;
                    n++;
                    @(posedge CLK); #1;
                    ramaddr = ramaddr + 32'h4;
                end else begin
                    @(posedge CLK); #1;
                end
            end
            chk("b2b_count", 32'(n), 32'd3);
            ramREN = 1'b0;
        end
        @(negedge CLK);
        chk("end_free", 32'(st), 32'(FREE));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
